// File: rtl/serial_add_arbiter.sv
// rtl/serial_add_arbiter.sv - round-robin arbiter sharing one serial adder between two requesters
module serial_add_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       adder_start,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  input  logic [8:0] adder_result,
  input  logic       adder_done,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [8:0] rsp_sum,
  output logic       rsp_err,
  input  logic       rsp_ready
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] timer;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       idle;

  // last_grant=1 means requester 1 was served last, so requester 0 wins a tie
  assign idle       = (state == IDLE);
  assign grant0     = req0_valid & (~req1_valid | last_grant);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = rst & idle & grant0;
  assign req1_ready = rst & idle & grant1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= 8'd0;
      last_grant  <= 1'b1;
      adder_start <= 1'b0;
      adder_a     <= 8'd0;
      adder_b     <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_sum     <= 9'd0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            adder_a     <= req0_a;
            adder_b     <= req0_b;
            rsp_id      <= 1'b0;
            adder_start <= 1'b1;
            state       <= LAUNCH;
          end else if (req1_ready) begin
            adder_a     <= req1_a;
            adder_b     <= req1_b;
            rsp_id      <= 1'b1;
            adder_start <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          adder_start <= 1'b0;
          timer       <= 8'd0;
          state       <= WAIT;
        end
        WAIT: begin
          // a done pulse in the final timer cycle still counts as success
          if (adder_done) begin
            rsp_sum   <= adder_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_sum   <= 9'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb/tb_serial_add_arbiter.sv - directed self-checking bench for serial_add_arbiter
module tb_serial_add_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_a = 8'd0;
  logic [7:0] req0_b = 8'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_a = 8'd0;
  logic [7:0] req1_b = 8'd0;
  logic       req1_ready;
  logic       adder_start;
  logic [7:0] adder_a;
  logic [7:0] adder_b;
  logic [8:0] adder_result = 9'd0;
  logic       adder_done = 1'b0;
  logic       rsp_valid;
  logic       rsp_id;
  logic [8:0] rsp_sum;
  logic       rsp_err;
  logic       rsp_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_add_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
    .adder_result(adder_result), .adder_done(adder_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick(2);
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready, adder_start, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_err} !== 31'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {req0_ready, req1_ready, adder_start, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_err});
    else pass_cnt++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL basic_ready: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    tick();
    req0_valid = 1'b0;
    total_cnt++;
    if ({adder_start, adder_a, adder_b} !== {1'b1, 16'h0503})
      $display("FAIL basic_start: got %h want 10503", {adder_start, adder_a, adder_b});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (adder_start !== 1'b0) $display("FAIL basic_start_pulse: got %b want 0", adder_start);
    else pass_cnt++;
    tick(7);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_early_rsp: got %b want 0", rsp_valid);
    else pass_cnt++;
    tick();
    adder_done = 1'b1; adder_result = 9'h008;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b0, 9'h008, 1'b0})
      $display("FAIL basic_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b0, 9'h008, 1'b0});
    else pass_cnt++;
    take_rsp();
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_rsp_taken: got %b want 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rr_first_tie: got %b want 10", {req0_ready, req1_ready});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({req0_ready, req1_ready, adder_a, adder_b} !== {2'b00, 16'h1122})
      $display("FAIL rr_launch0: got %h want 01122", {req0_ready, req1_ready, adder_a, adder_b});
    else pass_cnt++;
    tick();
    adder_done = 1'b1; adder_result = 9'h033;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b0, 9'h033, 1'b0, 2'b00})
      $display("FAIL rr_rsp0: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err, req0_ready, req1_ready},
               {1'b1, 1'b0, 9'h033, 1'b0, 2'b00});
    else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL rr_second_tie: got %b want 01", {req0_ready, req1_ready});
    else pass_cnt++;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    total_cnt++;
    if ({adder_start, adder_a, adder_b} !== {1'b1, 16'h3344})
      $display("FAIL rr_launch1: got %h want 13344", {adder_start, adder_a, adder_b});
    else pass_cnt++;
    tick();
    adder_done = 1'b1; adder_result = 9'h077;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b1, 9'h077, 1'b0})
      $display("FAIL rr_rsp1: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b1, 9'h077, 1'b0});
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_carry();
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    tick();
    req0_valid = 1'b0;
    tick();
    adder_done = 1'b1; adder_result = 9'h1FE;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_sum, rsp_sum[8], rsp_err} !== {1'b1, 9'h1FE, 1'b1, 1'b0})
      $display("FAIL carry_sum: got %h want %h", {rsp_valid, rsp_sum, rsp_sum[8], rsp_err}, {1'b1, 9'h1FE, 1'b1, 1'b0});
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_timeout();
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
    tick();
    req1_valid = 1'b0;
    tick(16);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL timeout_early: got %b want 0", rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b1, 9'h000, 1'b1})
      $display("FAIL timeout_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b1, 9'h000, 1'b1});
    else pass_cnt++;
    take_rsp();
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h08;
    tick();
    req1_valid = 1'b0;
    tick();
    adder_done = 1'b1; adder_result = 9'h00F;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b1, 9'h00F, 1'b0})
      $display("FAIL timeout_next_job: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b1, 9'h00F, 1'b0});
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_done_at_timeout();
    req0_valid = 1'b1; req0_a = 8'h50; req0_b = 8'h5B;
    tick();
    req0_valid = 1'b0;
    tick(16);
    adder_done = 1'b1; adder_result = 9'h0AB;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b0, 9'h0AB, 1'b0})
      $display("FAIL done_at_timeout: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b0, 9'h0AB, 1'b0});
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_back_pressure();
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    tick();
    req0_valid = 1'b0;
    tick();
    adder_done = 1'b1; adder_result = 9'h046;
    tick();
    adder_done = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adder_done = (i == 2);
      adder_result = 9'h1FF;
      #1;
      total_cnt++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_err, req0_ready, req1_ready, adder_start, adder_a, adder_b} !==
          {1'b1, 1'b0, 9'h046, 1'b0, 3'b000, 16'h1234})
        $display("FAIL hold_cycle%0d: got %h want %h", i,
                 {rsp_valid, rsp_id, rsp_sum, rsp_err, req0_ready, req1_ready, adder_start, adder_a, adder_b},
                 {1'b1, 1'b0, 9'h046, 1'b0, 3'b000, 16'h1234});
      else pass_cnt++;
      tick();
    end
    adder_done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    take_rsp();
    adder_done = 1'b1;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, adder_start} !== 2'b00) $display("FAIL idle_stray_done: got %b want 00", {rsp_valid, adder_start});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    req0_valid = 1'b1; req0_a = 8'h09; req0_b = 8'h09;
    tick();
    req0_valid = 1'b0;
    tick(4);
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready, adder_start, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_err} !== 31'd0)
      $display("FAIL midjob_reset_outputs: got %h want 0",
               {req0_ready, req1_ready, adder_start, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_err});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL midjob_no_rsp: got %b want 0", rsp_valid);
    else pass_cnt++;
    rst = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h22;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL midjob_fresh_ready: got %b want 01", {req0_ready, req1_ready});
    else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    total_cnt++;
    if ({adder_start, adder_a, adder_b} !== {1'b1, 16'h2022})
      $display("FAIL midjob_fresh_start: got %h want 12022", {adder_start, adder_a, adder_b});
    else pass_cnt++;
    tick();
    adder_done = 1'b1; adder_result = 9'h042;
    tick();
    adder_done = 1'b0;
    total_cnt++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b1, 9'h042, 1'b0})
      $display("FAIL midjob_fresh_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b1, 9'h042, 1'b0});
    else pass_cnt++;
    take_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_carry();
    test_timeout();
    test_done_at_timeout();
    test_back_pressure();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
